sprite_animator: RTL and testbench
==================================

# sprite_animator

Downstream consumer of the sprite state machine's `motion` code. On each video frame tick it advances a walk-cycle animation, integrates horizontal position, and emits the sprite index `sel` and X coordinate `shape_x` consumed by the color mapper. It turns "what the player is doing" into "which sprite bitmap to draw, and where".

## Interface
Parameters:
- `FRAME_DIV`, 6: frame ticks per walk-animation step (≥1).
- `WALK_FRAMES`, 4: walk-cycle length in frames (1..7).
- `STEP`, 2: pixels moved per frame tick while walking.
- `X_MIN`, 0: leftmost legal `shape_x`.
- `X_MAX`, 608: rightmost legal `shape_x` (screen width 640 minus sprite width 32).
- `X_INIT`, 290: `shape_x` after reset.

Ports:
- `Clk`, in, 1: system clock. One clock domain.
- `Reset`, in, 1: reset is synchronous and active-high.
- `frame_tick`, in, 1: one-cycle pulse per video frame (vsync-derived, already synchronized to `Clk`).
- `motion`, in, 4: motion code from the sprite state machine.
- `sel`, out, 4: sprite index for the color mapper, registered.
- `shape_x`, out, 11: sprite left edge in pixels, registered.
- `facing_left`, out, 1: current facing direction, registered.

## Operation
- Motion codes: 0 = IDLE_R, 1 = IDLE_L, 2 = WALK_R, 3 = WALK_L. Codes 4..15 are invalid.
- State register: one of IDLE_R, IDLE_L, WALK_R, WALK_L. State changes only on `frame_tick`. Between ticks everything holds.
- On `frame_tick` with a valid code:
  - The next state is the decoded code.
  - If the next state differs from the current state, clear `div_cnt` and `frame_idx` to 0.
  - If the state stays WALK_R or WALK_L:
    - `div_cnt` increments.
    - When `div_cnt == FRAME_DIV-1`, `div_cnt` wraps to 0 and `frame_idx` advances modulo `WALK_FRAMES`.
  - In IDLE states, `div_cnt` and `frame_idx` stay 0.
- On `frame_tick` with an invalid code: state, counters and `shape_x` all hold. No motion occurs.
- Position uses the next state, on the same tick:
  - WALK_R: `shape_x = min(shape_x + STEP, X_MAX)`.
  - WALK_L: `shape_x = max(shape_x - STEP, X_MIN)`.
  - Compute with 12-bit intermediates so the sum never wraps and the subtraction never underflows before saturation.
- `sel` mapping:
  - IDLE_R = 0.
  - WALK_R = 1 + `frame_idx`.
  - IDLE_L = `WALK_FRAMES` + 1.
  - WALK_L = `WALK_FRAMES` + 2 + `frame_idx`.
  - With the defaults, the range is 0..9.
- `facing_left` = 1 in IDLE_L and WALK_L.

## Timing
- Latency: a `frame_tick` sampled at rising edge N makes `sel`, `shape_x` and `facing_left` reflect the new values after edge N, i.e. one cycle.
- `motion` is sampled only in the cycle where `frame_tick` is high. Changes between ticks have no effect.
- Reset values: state IDLE_R, `sel` = 0, `shape_x` = `X_INIT`, `facing_left` = 0, `div_cnt` = 0, `frame_idx` = 0.
- `Reset` dominates `frame_tick` in the same cycle.
- Reset mid-walk returns to IDLE_R at `X_INIT` on the next edge.
- Back-to-back `frame_tick` in consecutive cycles is legal. Each tick is processed fully.
- At a boundary, walking into the wall keeps the WALK state and animation running while `shape_x` stays pinned at `X_MIN`/`X_MAX`.

## Structure
- Shared package `sprite_pkg`:
  - `motion_t` enum (IDLE_R = 0, IDLE_L = 1, WALK_R = 2, WALK_L = 3). The sprite state machine also imports it.
  - `anim_state_t`.
  - Constants `SCREEN_W` = 640 and `SPRITE_W` = 32.
- One natural sub-module: `sprite_x_integrator`. It takes `Clk`, `Reset`, an enable (`frame_tick`), direction, and a move flag, and holds the saturating `shape_x` register. The animation FSM and counters stay in the top level.

## Test plan
- Reset, then 3 ticks with `motion` = 0 → `sel` = 0, `shape_x` = 290, `facing_left` = 0 throughout.
- Hold `motion` = 2 for 13 ticks (defaults):
  - `sel` = 1 for ticks 1–5, then 2 at tick 6, 3 at tick 12.
  - `shape_x` = 290 + 2·13 = 316.
- In WALK_R at `frame_idx` 2, apply a tick with `motion` = 3 → `sel` = 6, `facing_left` = 1, `shape_x` decreases by 2. Then a tick with `motion` = 1 → `sel` = 5, `shape_x` unchanged.
- Left-wall saturation: start at `shape_x` = 3 (via `X_INIT` = 3) with `motion` = 3 → `shape_x` goes 1, 0, 0, 0 while `sel` still animates 6→7 after 6 ticks. Repeat mirrored at `X_MAX` = 608 with start 607.
- Invalid code and reset:
  - `motion` = 9 on a tick → all outputs hold.
  - `motion` changes with no tick → outputs hold.
  - `Reset` asserted in the same cycle as a tick with `motion` = 2 → `sel` = 0, `shape_x` = 290.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite types: motion codes from the sprite state machine and the
// animator's state encoding, plus the sprite-index mapping used by the animator.
package sprite_pkg;

   localparam int SCREEN_W = 640;
   localparam int SPRITE_W = 32;

   typedef enum logic [3:0] {
      IDLE_R = 4'd0,
      IDLE_L = 4'd1,
      WALK_R = 4'd2,
      WALK_L = 4'd3
   } motion_t;

   // State encoding deliberately equals the low two bits of a valid motion code.
   typedef logic [1:0] anim_state_t;

   localparam anim_state_t ST_IDLE_R = 2'd0;
   localparam anim_state_t ST_IDLE_L = 2'd1;
   localparam anim_state_t ST_WALK_R = 2'd2;
   localparam anim_state_t ST_WALK_L = 2'd3;

   function automatic logic is_walk(input anim_state_t s);
      return (s == ST_WALK_R) || (s == ST_WALK_L);
   endfunction

   function automatic logic [3:0] sprite_sel(input anim_state_t s,
                                             input logic [2:0]  idx,
                                             input logic [3:0]  walk_frames);
      logic [3:0] r;
      case (s)
         ST_IDLE_R: r = 4'd0;
         ST_WALK_R: r = 4'd1 + {1'b0, idx};
         ST_IDLE_L: r = walk_frames + 4'd1;
         default:   r = walk_frames + 4'd2 + {1'b0, idx};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sprite_x_integrator.sv
// Saturating horizontal position register; moves STEP pixels per enabled tick
// and pins at X_MIN / X_MAX instead of wrapping.
module sprite_x_integrator #(
   parameter int STEP   = 2,
   parameter int X_MIN  = 0,
   parameter int X_MAX  = 608,
   parameter int X_INIT = 290
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        en,
   input  logic        dir_left,
   input  logic        move,
   output logic [10:0] shape_x
);

   logic [11:0] x_wide;
   logic [11:0] sum;
   logic [11:0] lo_limit;
   logic [10:0] x_next;

   assign x_wide   = {1'b0, shape_x};
   assign sum      = x_wide + 12'(STEP);
   assign lo_limit = 12'(X_MIN) + 12'(STEP);

   // Left moves compare before subtracting so the difference never underflows.
   always_comb begin
      x_next = shape_x;
      if (move) begin
         if (dir_left)
            x_next = (x_wide < lo_limit) ? 11'(X_MIN) : 11'(x_wide - 12'(STEP));
         else
            x_next = (sum > 12'(X_MAX)) ? 11'(X_MAX) : sum[10:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         shape_x <= 11'(X_INIT);
      else if (en)
         shape_x <= x_next;
   end

endmodule

// File: rtl/sprite_animator.sv
// Turns the motion code into a walk-cycle sprite index, facing direction and
// X position, advancing only on video frame ticks.
module sprite_animator
   import sprite_pkg::*;
#(
   parameter int FRAME_DIV   = 6,
   parameter int WALK_FRAMES = 4,
   parameter int STEP        = 2,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 608,
   parameter int X_INIT      = 290
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic [3:0]  motion,
   output logic [3:0]  sel,
   output logic [10:0] shape_x,
   output logic        facing_left
);

   localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [2:0]       IDX_LAST = 3'(WALK_FRAMES - 1);
   localparam logic [3:0]       WF       = 4'(WALK_FRAMES);

   anim_state_t      state, state_d;
   logic [DIV_W-1:0] div_cnt, div_d, div_base;
   logic [2:0]       frame_idx, idx_d, idx_base;
   logic             accept;
   logic             move;
   logic             dir_left;

   assign accept   = frame_tick && (motion <= 4'(WALK_L));
   assign move     = is_walk(state_d);
   assign dir_left = (state_d == ST_WALK_L);

   // The tick that enters a walk state counts as the first animation tick, so
   // the first frame change lands exactly FRAME_DIV ticks after entry.
   always_comb begin
      state_d  = state;
      div_d    = div_cnt;
      idx_d    = frame_idx;
      div_base = div_cnt;
      idx_base = frame_idx;
      if (accept) begin
         state_d = anim_state_t'(motion[1:0]);
         if (state_d != state) begin
            div_base = '0;
            idx_base = '0;
         end
         if (is_walk(state_d)) begin
            if (div_base == DIV_LAST) begin
               div_d = '0;
               idx_d = (idx_base == IDX_LAST) ? 3'd0 : idx_base + 3'd1;
            end else begin
               div_d = div_base + 1'b1;
               idx_d = idx_base;
            end
         end else begin
            div_d = '0;
            idx_d = '0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= ST_IDLE_R;
         div_cnt     <= '0;
         frame_idx   <= '0;
         sel         <= 4'd0;
         facing_left <= 1'b0;
      end else begin
         state       <= state_d;
         div_cnt     <= div_d;
         frame_idx   <= idx_d;
         sel         <= sprite_sel(state_d, idx_d, WF);
         facing_left <= (state_d == ST_IDLE_L) || (state_d == ST_WALK_L);
      end
   end

   sprite_x_integrator #(
      .STEP   (STEP),
      .X_MIN  (X_MIN),
      .X_MAX  (X_MAX),
      .X_INIT (X_INIT)
   ) u_x (
      .Clk      (Clk),
      .Reset    (Reset),
      .en       (accept),
      .dir_left (dir_left),
      .move     (move),
      .shape_x  (shape_x)
   );

endmodule

// File: tb/tb_sprite_animator.sv
// Self-checking bench: three animators (mid-screen, near left wall, near right
// wall) share stimulus and are compared against a tick-counting reference model.
module tb_sprite_animator;

   localparam int NDUT      = 3;
   localparam int FRAME_DIV = 6;
   localparam int WALK_FR   = 4;
   localparam int STEP      = 2;
   localparam int XMIN      = 0;
   localparam int XMAX      = 608;
   localparam int XINIT [NDUT] = '{290, 3, 607};

   logic        Clk;
   logic        Reset;
   logic        frameTick;
   logic [3:0]  motion;
   logic [3:0]  dutSel [NDUT];
   logic [10:0] dutX   [NDUT];
   logic        dutFl  [NDUT];

   int total = 0;
   int bad   = 0;

   int mState [NDUT];
   int mTicks [NDUT];
   int mX     [NDUT];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sprite_animator #(
         .FRAME_DIV   (FRAME_DIV),
         .WALK_FRAMES (WALK_FR),
         .STEP        (STEP),
         .X_MIN       (XMIN),
         .X_MAX       (XMAX),
         .X_INIT      (XINIT[g])
      ) dut (
         .Clk         (Clk),
         .Reset       (Reset),
         .frame_tick  (frameTick),
         .motion      (motion),
         .sel         (dutSel[g]),
         .shape_x     (dutX[g]),
         .facing_left (dutFl[g])
      );
   end

   // Model: state 0..3 as motion codes, walk frame = ticks spent walking / FRAME_DIV.
   function automatic int modelSel(input int k);
      int idx;
      idx = (mTicks[k] / FRAME_DIV) % WALK_FR;
      case (mState[k])
         0:       return 0;
         2:       return 1 + idx;
         1:       return WALK_FR + 1;
         default: return WALK_FR + 2 + idx;
      endcase
   endfunction

   task automatic modelUpdate(input logic rst, input logic tick, input logic [3:0] mot);
      for (int k = 0; k < NDUT; k++) begin
         if (rst) begin
            mState[k] = 0;
            mTicks[k] = 0;
            mX[k]     = XINIT[k];
         end else if (tick && mot < 4) begin
            if (int'(mot) != mState[k]) mTicks[k] = 0;
            mState[k] = int'(mot);
            if (mState[k] >= 2) mTicks[k] = mTicks[k] + 1;
            else                mTicks[k] = 0;
            if (mState[k] == 2) mX[k] = (mX[k] + STEP > XMAX) ? XMAX : mX[k] + STEP;
            if (mState[k] == 3) mX[k] = (mX[k] - STEP < XMIN) ? XMIN : mX[k] - STEP;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      int expSel;
      int expFl;
      for (int k = 0; k < NDUT; k++) begin
         expSel = modelSel(k);
         expFl  = (mState[k] == 1 || mState[k] == 3) ? 1 : 0;
         total++;
         assert (int'(dutSel[k]) === expSel) else begin
            bad++;
            $error("[TB] FAIL %s dut%0d sel got=%0d exp=%0d", tag, k, dutSel[k], expSel);
         end
         total++;
         assert (int'(dutX[k]) === mX[k]) else begin
            bad++;
            $error("[TB] FAIL %s dut%0d shape_x got=%0d exp=%0d", tag, k, dutX[k], mX[k]);
         end
         total++;
         assert (int'(dutFl[k]) === expFl) else begin
            bad++;
            $error("[TB] FAIL %s dut%0d facing_left got=%0d exp=%0d", tag, k, dutFl[k], expFl);
         end
      end
   endtask

   task automatic checkConst(input string tag, input int k, input int expSel, input int expX);
      total++;
      assert (int'(dutSel[k]) === expSel) else begin
         bad++;
         $error("[TB] FAIL %s dut%0d sel got=%0d exp=%0d", tag, k, dutSel[k], expSel);
      end
      total++;
      assert (int'(dutX[k]) === expX) else begin
         bad++;
         $error("[TB] FAIL %s dut%0d shape_x got=%0d exp=%0d", tag, k, dutX[k], expX);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic tick, input logic [3:0] mot,
                                input string tag);
      Reset     = rst;
      frameTick = tick;
      motion    = mot;
      @(posedge Clk);
      modelUpdate(rst, tick, mot);
      #1;
      checkOutput(tag);
      Reset     = 1'b0;
      frameTick = 1'b0;
   endtask

   initial begin
      logic       rRst;
      logic       rTick;
      logic [3:0] rMot;

      Reset     = 1'b1;
      frameTick = 1'b0;
      motion    = 4'd0;

      applyStimulus(1'b1, 1'b0, 4'd0, "reset");
      checkConst("reset_const", 0, 0, 290);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'd0, "idle_r");
      checkConst("idle_const", 0, 0, 290);

      for (int i = 1; i <= 13; i++) begin
         applyStimulus(1'b0, 1'b1, 4'd2, "walk_r");
         if (i == 5)  checkConst("walk_r_t5", 0, 1, 300);
         if (i == 6)  checkConst("walk_r_t6", 0, 2, 302);
         if (i == 12) checkConst("walk_r_t12", 0, 3, 314);
      end
      checkConst("walk_r_t13", 0, 3, 316);

      applyStimulus(1'b0, 1'b1, 4'd3, "turn_left");
      checkConst("turn_left_const", 0, 6, 314);
      applyStimulus(1'b0, 1'b1, 4'd1, "idle_l");
      checkConst("idle_l_const", 0, 5, 314);

      applyStimulus(1'b1, 1'b0, 4'd0, "reset2");
      for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 4'd3, "left_wall");
      checkConst("left_wall_const", 1, 7, 0);

      applyStimulus(1'b1, 1'b0, 4'd0, "reset3");
      for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b1, 4'd2, "right_wall");
      checkConst("right_wall_const", 2, 2, 608);

      applyStimulus(1'b0, 1'b1, 4'd9, "invalid_code");
      checkConst("invalid_const", 2, 2, 608);
      applyStimulus(1'b0, 1'b0, 4'd3, "no_tick");
      applyStimulus(1'b0, 1'b0, 4'd1, "no_tick2");
      checkConst("no_tick_const", 0, 2, 302);

      applyStimulus(1'b1, 1'b1, 4'd2, "reset_vs_tick");
      checkConst("reset_vs_tick_const", 0, 0, 290);

      for (int i = 0; i < 400; i++) begin
         rRst  = ($urandom_range(0, 59) == 0);
         rTick = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) < 8) rMot = 4'($urandom_range(0, 3));
         else                          rMot = 4'($urandom_range(4, 15));
         applyStimulus(rRst, rTick, rMot, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
